pattern_serial_tx: RTL and testbench

//  Transmitter end of the serial pattern link: on command, shifts a fixed PAT_LEN-bit pattern (default 1011)
//  MSB-first onto a 1-bit line, one bit per clock, repeated a requested number of times with optional idle gap.

---
 rtl/pattern_serial_tx.sv | 163 ++++++++++++++++
 tb/tb_pattern_serial_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: shifts PATTERN MSB-first, one bit per clock,
// repeated reps times with GAP idle cycles between repetitions.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   start     launch request, sampled only in IDLE
//   reps      repetition count latched with start (0 acts as 1)
//   abort     stop a running transmission at the next edge
//   ser_out   serial line (registered)
//   ser_valid high while ser_out carries a pattern bit
//   busy      high in SEND and GAP
//   done      one-cycle pulse after the last bit of the last repetition
//   aborted   one-cycle pulse after an accepted abort
module pattern_serial_tx #(
  parameter int unsigned        PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1011,
  parameter logic               IDLE_BIT = 1'b0,
  parameter int unsigned        GAP      = 1,
  parameter int unsigned        CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam int unsigned IW =
    (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam int unsigned GW =
    (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [IW-1:0] IDX_MSB =
    IW'(PAT_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);
  localparam logic HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [GW-1:0]    r_gap;
  logic [CNT_W-1:0] r_reps_left;

  logic [IW-1:0] w_idx_dn;
  logic          w_pat_end;
  logic          w_more;
  logic          w_msb_bit;
  logic          w_next_bit;

  assign w_idx_dn   = r_idx - 1'b1;
  assign w_pat_end  = (r_idx == '0);
  // reps_left is never 0 inside SEND, so "not one" means more to send
  assign w_more     = (r_reps_left != ONE);
  assign w_msb_bit  = PATTERN[IDX_MSB];
  assign w_next_bit = PATTERN[w_idx_dn];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_gap       <= '0;
      r_reps_left <= '0;
      ser_out     <= IDLE_BIT;
      ser_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_reps_left <= (reps == '0) ? ONE : reps;
            r_idx       <= IDX_MSB;
            r_state     <= S_SEND;
            ser_out     <= w_msb_bit;
            ser_valid   <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_reps_left <= '0;
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            busy        <= 1'b0;
            aborted     <= 1'b1;
          end else if (!w_pat_end) begin
            r_idx   <= w_idx_dn;
            ser_out <= w_next_bit;
          end else begin
            r_reps_left <= r_reps_left - ONE;
            if (w_more) begin
              if (HAS_GAP) begin
                r_state   <= S_GAP;
                r_gap     <= GAP_LAST;
                ser_out   <= IDLE_BIT;
                ser_valid <= 1'b0;
              end else begin
                // back-to-back repetition, no bubble
                r_idx   <= IDX_MSB;
                ser_out <= w_msb_bit;
              end
            end else begin
              r_state   <= S_DONE;
              ser_out   <= IDLE_BIT;
              ser_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_gap       <= '0;
            r_reps_left <= '0;
            ser_out     <= IDLE_BIT;
            ser_valid   <= 1'b0;
            busy        <= 1'b0;
            aborted     <= 1'b1;
          end else if (r_gap == '0) begin
            r_state   <= S_SEND;
            r_idx     <= IDX_MSB;
            ser_out   <= w_msb_bit;
            ser_valid <= 1'b1;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          ser_out   <= IDLE_BIT;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Bench for pattern_serial_tx: GAP=1 and GAP=0 instances share stimulus
// and are checked every cycle against a queue-based expected-output model.
module tb_pattern_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] reps;
  logic       abort;

  logic s0, v0, b0, d0, a0;
  logic s1, v1, b1, d1, a1;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  pattern_serial_tx #(.GAP(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start),
    .reps(reps), .abort(abort),
    .ser_out(s0), .ser_valid(v0), .busy(b0),
    .done(d0), .aborted(a0)
  );

  pattern_serial_tx #(.GAP(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start),
    .reps(reps), .abort(abort),
    .ser_out(s1), .ser_valid(v1), .busy(b1),
    .done(d1), .aborted(a1)
  );

  wire [4:0] o0 = {s0, v0, b0, d0, a0};
  wire [4:0] o1 = {s1, v1, b1, d1, a1};

  // expected vector layout: {ser_out, valid, busy, done, aborted}
  localparam logic [4:0] X_IDLE = 5'b00000;
  localparam logic [4:0] X_GAP  = 5'b00100;
  localparam logic [4:0] X_DONE = 5'b00010;
  localparam logic [4:0] X_ABT  = 5'b00001;

  logic [4:0] pend [2][$];
  logic [4:0] cur  [2];
  int         gaps [2];
  logic [3:0] pat;

  initial begin
    gaps[0] = 1;
    gaps[1] = 0;
    pat     = 4'b1011;
    cur[0]  = X_IDLE;
    cur[1]  = X_IDLE;
  end

  // Model: a transmission is the list of cycles it will produce.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pend[k].delete();
        cur[k] = X_IDLE;
      end else if (cur[k][2] && abort) begin
        pend[k].delete();
        cur[k] = X_ABT;
      end else if (pend[k].size() > 0) begin
        cur[k] = pend[k].pop_front();
      end else if (!cur[k][1] && start) begin
        int n;
        n = (reps == 0) ? 1 : int'(reps);
        for (int r = 0; r < n; r++) begin
          if (r > 0)
            for (int g = 0; g < gaps[k]; g++)
              pend[k].push_back(X_GAP);
          for (int i = 3; i >= 0; i--)
            pend[k].push_back({pat[i], 4'b1100});
        end
        pend[k].push_back(X_DONE);
        cur[k] = pend[k].pop_front();
      end else begin
        cur[k] = X_IDLE;
      end
    end
    #1;
    if (model_on) begin
      checks++;
      if (o0 !== cur[0]) begin
        errors++;
        $display("FAIL model dut0 t=%0t got=%b exp=%b",
                 $time, o0, cur[0]);
      end
      checks++;
      if (o1 !== cur[1]) begin
        errors++;
        $display("FAIL model dut1 t=%0t got=%b exp=%b",
                 $time, o1, cur[1]);
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [4:0] got,
                     input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [3:0]  e4;
  logic [11:0] e12;
  bit          saw_done;

  initial begin
    e4    = 4'b1011;
    e12   = 12'b101110111011;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    reps  = 8'd0;
    repeat (3) cyc();
    model_on = 1'b1;
    reset = 1'b0;
    cyc();
    chk("reset0", o0, X_IDLE);
    chk("reset1", o1, X_IDLE);

    // T1 + T5: reps=1, stray starts at c2 and c5
    start = 1'b1; reps = 8'd1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1 bit", o0, {e4[3-i], 4'b1100});
      start = (i == 1);
      cyc();
    end
    start = 1'b0;
    chk("t1 done", o0, X_DONE);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t5 idle", o0, X_IDLE);
    repeat (2) cyc();

    // T2: reps=2 with one gap cycle
    start = 1'b1; reps = 8'd2;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2 bitA", o0, {e4[3-i], 4'b1100});
      cyc();
    end
    chk("t2 gap", o0, X_GAP);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("t2 bitB", o0, {e4[3-i], 4'b1100});
      cyc();
    end
    chk("t2 done", o0, X_DONE);
    repeat (2) cyc();

    // T3: reps=0 acts as 1
    start = 1'b1; reps = 8'd0;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("t3 r0 done", o0, X_DONE);
    repeat (2) cyc();

    // T3: GAP=0 build, reps=3 back-to-back
    start = 1'b1; reps = 8'd3;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("t3 bit", o1, {e12[11-i], 4'b1100});
      cyc();
    end
    chk("t3 done", o1, X_DONE);
    repeat (4) cyc();

    // T4: abort during a long run
    start = 1'b1; reps = 8'd5;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t4 abt0", o0, X_ABT);
    chk("t4 abt1", o1, X_ABT);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (d0 || d1) saw_done = 1'b1;
      cyc();
    end
    chk("t4 nodone", {4'b0, saw_done}, 5'b0);

    // T6: reset mid-transfer then clean restart
    start = 1'b1; reps = 8'd1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6 rst0", o0, X_IDLE);
    chk("t6 rst1", o1, X_IDLE);
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6 bit", o0, {e4[3-i], 4'b1100});
      cyc();
    end
    chk("t6 done", o0, X_DONE);
    repeat (2) cyc();

    // maximum count, model-checked
    start = 1'b1; reps = 8'd255;
    cyc();
    start = 1'b0;
    repeat (1300) cyc();

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      reps  = 8'($urandom_range(0, 3));
      abort = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 250) == 0);
      cyc();
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
    repeat (30) cyc();
    model_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
